result_unpack_fifo: RTL

//  Output-side counterpart of the 32->64 operand buffer. Accepts 64-bit result pairs from the

---
 rtl/result_unpack_fifo.sv | 118 +++++++++++
 1 files changed

// File: rtl/result_unpack_fifo.sv
// result_unpack_fifo: queues 64-bit result pairs and returns them as a
// first-word-fall-through 32-bit word stream. The upper half is emitted
// first, then the lower half.
// Optional feature: define RESULT_FIFO_ERR_EN to add err_clr/drop_err
// (a sticky flag for pushes attempted while full).
module result_unpack_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [63:0]   in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [31:0]   out_data,
    input  logic          out_ready,
    output logic          out_last,
    output logic [AW:0]   level,
    output logic          empty,
    output logic          full
`ifdef RESULT_FIFO_ERR_EN
    ,
    input  logic          err_clr,
    output logic          drop_err
`endif
);

    localparam int unsigned PW = 64;
    localparam int unsigned WW = 32;
    localparam int unsigned LW = AW + 1;

    logic [PW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          half;

    logic          push;
    logic          pop;
    logic          pop_pair;
    logic [LW-1:0] level_nxt;
    logic [PW-1:0] rd_pair;

    // Handshake decode; in_ready comes from the registered full flag only
    always_comb begin
        in_ready  = !full;
        out_valid = !empty;
        push      = in_valid && !full;
        pop       = !empty && out_ready;
        pop_pair  = pop && half;
    end

    // Occupancy after this cycle; a push and a pair release cancel out
    always_comb begin
        level_nxt = level;
        case ({push, pop_pair})
            2'b10:   level_nxt = level + LW'(1);
            2'b01:   level_nxt = level - LW'(1);
            default: level_nxt = level;
        endcase
    end

    // Word select from the head entry; zero while nothing is stored
    always_comb begin
        rd_pair  = mem[rd_ptr];
        out_data = '0;
        if (!empty) begin
            out_data = half ? rd_pair[WW-1:0] : rd_pair[PW-1:WW];
        end
        out_last = !empty && half && (level == LW'(1));
    end

    // Pair storage; contents need no reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // Pointers, half-select and occupancy flags
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            half   <= 1'b0;
            level  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                half <= !half;
            end
            if (pop_pair) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            level <= level_nxt;
            empty <= (level_nxt == '0);
            full  <= (level_nxt == LW'(DEPTH));
        end
    end

`ifdef RESULT_FIFO_ERR_EN
    // Sticky drop flag: a push attempt while full sets it, and set beats clear
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_err <= 1'b0;
        end else if (in_valid && full) begin
            drop_err <= 1'b1;
        end else if (err_clr) begin
            drop_err <= 1'b0;
        end
    end
`endif

endmodule
